// File: rtl/ac3_acc_ctrl_pkg.sv
// Shared types and width helpers for the AC3 accumulator path.
// Used by the controller, the AC3 register and the adder tree.
package ac3_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        WAIT,
        DONE
    } state_t;

    function automatic int psum_w(input int m, input int pa, input int pw);
        return $clog2(m) + pa + pw + 1;
    endfunction

    // Headroom of clog2(mno) bits covers mno full-scale partial sums.
    function automatic int acc_w(input int m, input int pa, input int pw, input int mno);
        return $clog2(m) + pa + pw + $clog2(mno) + 1;
    endfunction

    function automatic int cnt_w(input int mno);
        return $clog2(mno + 1);
    endfunction

endpackage

// File: rtl/ac3_acc_ctrl_if.sv
// Partial-sum input stream and result output stream of the AC3 controller.
// master = upstream tree / downstream consumer side, slave = controller side.
interface ac3_acc_ctrl_if
    import ac3_pkg::*;
#(
    parameter int PSUM_W = psum_w(16, 8, 4),
    parameter int ACC_W  = acc_w(16, 8, 4, 288)
);
    logic signed [PSUM_W-1:0] psum;
    logic                     psum_valid;
    logic                     psum_ready;
    logic signed [ACC_W-1:0]  res;
    logic                     res_valid;
    logic                     res_ready;

    modport master (
        output psum, psum_valid, res_ready,
        input  psum_ready, res, res_valid
    );

    modport slave (
        input  psum, psum_valid, res_ready,
        output psum_ready, res, res_valid
    );
endinterface

// File: rtl/ac3_acc_ctrl_op_cnt.sv
// Operand counter for one job: sync clear, increment enable, and a flag
// that is high when the next increment reaches the latched operand count.
module ac3_op_cnt #(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic             last
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last = (({1'b0, count} + (CNT_W + 1)'(1)) == {1'b0, limit});

endmodule

// File: rtl/ac3_acc_ctrl.sv
// AC3 accumulator sequencer: clears the register, folds accepted partial sums
// into it and hands the final sum out. Optional AC3_ACC_OVF_EN adds a sticky overflow flag.
//
// state | meaning
// IDLE  | waiting for start; acc_d forced to 0
// CLEAR | one-cycle register clear
// ACCUM | accepting psum beats until num_ops have been taken
// WAIT  | register captures the last write
// DONE  | res/res_valid held until res_ready
module ac3_acc_ctrl
    import ac3_pkg::*;
#(
    parameter int  M      = 16,
    parameter int  Pa     = 8,
    parameter int  Pw     = 4,
    parameter int  MNO    = 288,
    localparam int PSUM_W = psum_w(M, Pa, Pw),
    localparam int ACC_W  = acc_w(M, Pa, Pw, MNO),
    localparam int CNT_W  = cnt_w(MNO)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_ops,
    input  logic signed [ACC_W-1:0] acc_q,
    output logic signed [ACC_W-1:0] acc_d,
    output logic                    acc_w_en,
    output logic                    acc_valid,
    output logic                    acc_cl_en,
    output logic                    busy,
    output logic                    err,
    output logic                    ovf,
    ac3_acc_ctrl_if.slave           bus
);
    state_t state, state_next;

    logic [CNT_W-1:0]        ops;
    logic                    cnt_clr;
    logic                    cnt_inc;
    logic                    cnt_last;
    logic                    reject;
    logic                    accept;
    logic signed [ACC_W-1:0] psum_ext;
    logic signed [ACC_W-1:0] sum;

    assign reject   = start && (num_ops > CNT_W'(MNO));
    assign accept   = start && !reject;
    assign psum_ext = {{(ACC_W - PSUM_W){bus.psum[PSUM_W-1]}}, bus.psum};
    assign sum      = acc_q + psum_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ops   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && accept) begin
                ops <= num_ops;
            end
            err <= (state == IDLE) && reject;
        end
    end

    ac3_op_cnt #(
        .CNT_W (CNT_W)
    ) u_op_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .limit (ops),
        .last  (cnt_last)
    );

    always_comb begin
        state_next = state;
        acc_d      = acc_q;
        acc_w_en   = 1'b0;
        acc_cl_en  = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                acc_d = '0;
                if (accept) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                acc_cl_en  = 1'b1;
                cnt_clr    = 1'b1;
                state_next = (ops == '0) ? DONE : ACCUM;
            end
            ACCUM: begin
                if (bus.psum_valid) begin
                    acc_w_en = 1'b1;
                    acc_d    = sum;
                    cnt_inc  = 1'b1;
                    if (cnt_last) begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                state_next = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_next = IDLE;
                    cnt_clr    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign acc_valid      = acc_w_en;
    assign busy           = (state != IDLE);
    assign bus.psum_ready = (state == ACCUM);
    assign bus.res_valid  = (state == DONE);
    assign bus.res        = (state == DONE) ? acc_q : '0;

`ifdef AC3_ACC_OVF_EN
    logic ovf_flag;

    // Two's-complement overflow: same operand signs, result sign differs.
    always_ff @(posedge clk) begin
        if (rst || acc_cl_en) begin
            ovf_flag <= 1'b0;
        end else if (acc_w_en && (acc_q[ACC_W-1] == psum_ext[ACC_W-1])
                     && (sum[ACC_W-1] != acc_q[ACC_W-1])) begin
            ovf_flag <= 1'b1;
        end
    end

    assign ovf = ovf_flag;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ac3_acc_ctrl.sv
// Scoreboard bench for ac3_acc_ctrl: the bench owns the AC3 register model,
// pushes each job's expected sum and a monitor checks results as they appear.
module tb_ac3_acc_ctrl;
    import ac3_pkg::*;

    localparam int MNO    = 288;
    localparam int PSUM_W = psum_w(16, 8, 4);
    localparam int ACC_W  = acc_w(16, 8, 4, MNO);
    localparam int CNT_W  = cnt_w(MNO);

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [CNT_W-1:0]        num_ops = '0;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic                    acc_w_en, acc_valid, acc_cl_en, busy, err, ovf;
    logic                    preload_en = 1'b0;
    logic signed [ACC_W-1:0] preload_val = '0;

    ac3_acc_ctrl_if bus ();

    ac3_acc_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_ops   (num_ops),
        .acc_q     (acc_q),
        .acc_d     (acc_d),
        .acc_w_en  (acc_w_en),
        .acc_valid (acc_valid),
        .acc_cl_en (acc_cl_en),
        .busy      (busy),
        .err       (err),
        .ovf       (ovf),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // AC3 register model; preload lets the bench force a near-full-scale value.
    always @(posedge clk) begin
        if (rst)             acc_q <= '0;
        else if (acc_cl_en)  acc_q <= '0;
        else if (preload_en) acc_q <= preload_val;
        else if (acc_w_en)   acc_q <= acc_d;
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    logic signed [ACC_W-1:0] exp_q[$];
    int                      n_cl = 0;
    int                      n_w = 0;
    bit                      prev_hold = 0;
    logic signed [ACC_W-1:0] prev_res;
    logic signed [ACC_W-1:0] e_d;
    logic signed [ACC_W-1:0] e_res;

    always @(negedge clk) begin
        if (!rst) begin
            if (acc_cl_en) n_cl++;
            if (acc_w_en || acc_valid) chk("acc_valid_eq_w_en", acc_valid, acc_w_en);
            if (acc_w_en) begin
                n_w++;
                e_d = ACC_W'(longint'(acc_q) + longint'(bus.psum));
                chk("acc_d_sum", acc_d, e_d);
                chk("w_en_needs_valid", bus.psum_valid, 1);
                chk("cl_w_exclusive", acc_cl_en, 0);
            end
            if (prev_hold) begin
                chk("res_valid_hold", bus.res_valid, 1);
                chk("res_value_hold", bus.res, prev_res);
            end
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() > 0) begin
                    e_res = exp_q.pop_front();
                    chk("res", bus.res, e_res);
                end else begin
                    chk("res_unexpected", exp_q.size(), 1);
                end
`ifndef AC3_ACC_OVF_EN
                chk("ovf_tied_low", ovf, 0);
`endif
            end
            prev_hold = bus.res_valid && !bus.res_ready;
            prev_res  = bus.res;
        end else begin
            prev_hold = 0;
        end
    end

    int plist[$];
    int vpat[$];
    int start_cyc, first_beat_cyc, last_beat_cyc, rv_cyc;

    task automatic run_job(input int n, input int vpct, input int hold);
        int     vals[$];
        longint total;
        int     i, t;
        bit     acc;
        logic signed [ACC_W-1:0] e;
        total = 0;
        for (int k = 0; k < n; k++) begin
            int v;
            v = (k < plist.size()) ? plist[k] : int'($urandom_range(131071)) - 65536;
            vals.push_back(v);
            total += v;
        end
        plist.delete();
        e = ACC_W'(total);
        exp_q.push_back(e);
        bus.res_ready = (hold == 0);
        start   = 1'b1;
        num_ops = CNT_W'(n);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        i = 0;
        t = 0;
        while (i < n && t < 2000) begin
            if (t < vpat.size()) bus.psum_valid = vpat[t][0];
            else bus.psum_valid = ($urandom_range(99) < vpct);
            bus.psum = PSUM_W'(vals[i]);
            @(negedge clk);
            acc = bus.psum_valid && bus.psum_ready;
            if (acc) begin
                if (i == 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
            end
            @(posedge clk); #1;
            if (acc) i++;
            t++;
        end
        vpat.delete();
        bus.psum_valid = 1'b0;
        if (t >= 2000) chk("beat_timeout", i, n);
        if (n > 0) chk("psum_ready_drop", bus.psum_ready, 0);
        t = 0;
        while (!bus.res_valid && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        rv_cyc = cyc;
        chk("res_valid_seen", bus.res_valid, 1);
        if (hold > 0) begin
            start   = 1'b1;
            num_ops = CNT_W'(1);
            repeat (hold) begin @(posedge clk); #1; end
            chk("hold_busy", busy, 1);
            chk("hold_no_err", err, 0);
            start = 1'b0;
            bus.res_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("idle_after_result", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, w0, k, t;
        bit a;
        bus.psum = '0;
        bus.psum_valid = 1'b0;
        bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_psum_ready", bus.psum_ready, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res", bus.res, 0);
        chk("rst_err", err, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_cl", acc_cl_en, 0);
        chk("rst_w", acc_w_en, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        c0 = n_cl; w0 = n_w;
        plist = {5, -2, 7};
        run_job(3, 100, 0);
        chk("t1_clear_pulses", n_cl - c0, 1);
        chk("t1_writes", n_w - w0, 3);
        chk("t1_start_latency", first_beat_cyc - start_cyc, 2);
        chk("t1_result_latency", rv_cyc - last_beat_cyc, 2);

        w0 = n_w;
        plist = {1, 2, 3, 4};
        vpat  = {1, 0, 1, 1, 0, 1};
        run_job(4, 100, 0);
        chk("t2_writes", n_w - w0, 4);

        c0 = n_cl; w0 = n_w;
        run_job(0, 100, 0);
        chk("t3_clear_pulses", n_cl - c0, 1);
        chk("t3_writes", n_w - w0, 0);

        start = 1'b1;
        num_ops = CNT_W'(MNO + 1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("t4_err_pulse", err, 1);
        chk("t4_busy", busy, 0);
        @(posedge clk); #1;
        chk("t4_err_one_cycle", err, 0);
        chk("t4_busy_after", busy, 0);
        plist = {3, 4};
        run_job(2, 100, 0);

        plist = {100, -50, 25};
        run_job(3, 100, 5);

        start = 1'b1;
        num_ops = CNT_W'(6);
        @(posedge clk); #1;
        start = 1'b0;
        bus.psum = PSUM_W'(11);
        bus.psum_valid = 1'b1;
        k = 0; t = 0;
        while (k < 2 && t < 20) begin
            @(negedge clk);
            a = bus.psum_valid && bus.psum_ready;
            @(posedge clk); #1;
            if (a) k++;
            t++;
        end
        bus.psum_valid = 1'b0;
        chk("t6_two_beats", k, 2);
        chk("t6_busy_pre", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_busy", busy, 0);
        chk("t6_psum_ready", bus.psum_ready, 0);
        chk("t6_w_en", acc_w_en, 0);
        chk("t6_valid", acc_valid, 0);
        chk("t6_cl", acc_cl_en, 0);
        chk("t6_res_valid", bus.res_valid, 0);
        chk("t6_res", bus.res, 0);
        chk("t6_acc_d", acc_d, 0);
        chk("t6_err", err, 0);
        chk("t6_ovf", ovf, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        plist = {-9};
        run_job(1, 100, 0);

`ifdef AC3_ACC_OVF_EN
        e_res = ACC_W'(longint'((1 << (ACC_W - 1)) - 10) + 100);
        exp_q.push_back(e_res);
        start = 1'b1;
        num_ops = CNT_W'(1);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        preload_val = ACC_W'((1 << (ACC_W - 1)) - 10);
        preload_en = 1'b1;
        @(posedge clk); #1;
        preload_en = 1'b0;
        bus.psum = PSUM_W'(100);
        bus.psum_valid = 1'b1;
        @(posedge clk); #1;
        bus.psum_valid = 1'b0;
        chk("ovf_set", ovf, 1);
        t = 0;
        while (busy && t < 20) begin @(posedge clk); #1; t++; end
        chk("ovf_job_done", busy, 0);
        chk("ovf_sticky_idle", ovf, 1);
        exp_q.push_back('0);
        start = 1'b1;
        num_ops = '0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ovf_until_clear", ovf, 1);
        @(posedge clk); #1;
        chk("ovf_cleared", ovf, 0);
        t = 0;
        while (busy && t < 20) begin @(posedge clk); #1; t++; end
        chk("ovf_clear_job_done", busy, 0);
`endif

        for (int j = 0; j < MNO; j++) plist.push_back(65535);
        run_job(MNO, 100, 0);

        for (int j = 0; j < 25; j++) begin
            run_job(int'($urandom_range(12, 1)), int'($urandom_range(100, 50)),
                    int'($urandom_range(3, 0)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ac3_acc_ctrl.md
Name: ac3_acc_ctrl

Overview:
- Upstream sequencer for the AC3 accumulator register in the DP_1x64 datapath.
- Accepts a stream of signed partial sums from the multiplier/adder tree and counts operands against a per-job operand count.
- Forms the next accumulator value from the register's feedback and drives the register's clear, write and valid strobes.
- Presents the final sum on a valid/ready result port.

Parameters:
M, 16, products per partial sum (adder-tree fan-in)
Pa, 8, activation precision in bits
Pw, 4, weight precision in bits
MNO, 288, max operands per job (3x3xN_filter_max/16)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  job request, sampled in IDLE only
num_ops  in  $clog2(MNO+1)  operand count for the job, sampled with start
psum  in  PSUM_W=$clog2(M)+Pa+Pw+1  signed partial sum
psum_valid  in  1  psum qualifier
psum_ready  out  1  controller accepts psum this cycle
acc_q  in  ACC_W=$clog2(M)+Pa+Pw+$clog2(MNO)+1  accumulator register feedback
acc_d  out  ACC_W  next accumulator value (register inr)
acc_w_en  out  1  register write enable
acc_valid  out  1  register valid strobe
acc_cl_en  out  1  register clear
res  out  ACC_W  final sum
res_valid  out  1  result qualifier
res_ready  in  1  downstream consumer accepts res
busy  out  1  job in progress (state != IDLE)
err  out  1  one-cycle pulse on a rejected start
ovf  out  1  sticky signed-overflow flag (see Optional Feature)

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, operand counter 0. psum_ready, acc_w_en, acc_valid, acc_cl_en, res_valid, busy, err and ovf are all 0. res is 0.
- Reset has priority over every other event, including mid-job: the job is abandoned with no result. The register's own async reset is driven from the same top-level source.
- States:
  - IDLE -> CLEAR when start=1 and num_ops<=MNO. num_ops is latched at this transition.
  - start=1 with num_ops>MNO: err=1 for one cycle, stay in IDLE.
  - CLEAR: acc_cl_en=1 for exactly one cycle, then -> ACCUM. If the latched num_ops==0, -> DONE instead.
  - ACCUM: psum_ready=1.
    - A beat is accepted when psum_valid&psum_ready. On that cycle acc_w_en=acc_valid=1 and acc_d=acc_q+sign_extend(psum), and the counter increments.
    - Back-to-back beats are allowed: acc_q reflects the previous write on the next cycle.
    - No valid beat: acc_w_en=acc_valid=0 and acc_d holds.
    - When the accepted beat makes counter==num_ops: -> WAIT. psum_ready drops the next cycle.
  - WAIT: one cycle so the register captures the last write.
  - DONE: res=acc_q, res_valid=1 held stable until res_ready. On the cycle res_valid&res_ready -> IDLE and the counter clears.
- start outside IDLE is ignored (no err).
- Latencies:
  - start to first possible psum acceptance: 2 cycles.
  - Last beat to res_valid: 2 cycles.
  - res_ready already high on entry to DONE: 1-cycle result.
- Arithmetic:
  - ACC_W holds MNO full-scale sums without overflow; wrap-around is two's complement.
  - acc_d is 0 whenever not writing in IDLE.
- acc_cl_en and acc_w_en are never high in the same cycle.

Optional Feature:
- Macro: AC3_ACC_OVF_EN.
- Defined:
  - Per accepted beat, signed overflow of acc_q+psum at ACC_W is detected (operand signs equal, sum sign differs).
  - ovf is set and stays set until the next CLEAR or reset.
- Undefined: ovf is tied 0 and no detection logic is built.

Decomposition:
- Package ac3_pkg:
  - state enum {IDLE, CLEAR, ACCUM, WAIT, DONE}
  - width functions psum_w(M,Pa,Pw), acc_w(M,Pa,Pw,MNO) and cnt_w(MNO), shared with the AC3 register and the adder tree.
- Sub-module ac3_op_cnt: operand counter with sync clear, increment enable, and a terminal-match output against the latched num_ops.

Test Plan:
- num_ops=3, psum sequence 5,-2,7, continuous valid:
  - acc_cl_en pulses once.
  - Three acc_w_en pulses.
  - res=10, res_valid 2 cycles after the last beat.
- num_ops=4 with psum_valid gaps (1-0-1-1-0-1), psums 1,2,3,4:
  - Writes occur only on valid cycles.
  - res=10.
  - psum_ready low after the 4th beat.
- num_ops=0: CLEAR then DONE, res=0, no acc_w_en.
- num_ops=MNO+1: err pulses one cycle, busy stays 0. A following start with num_ops=2 (psums 3,4) completes normally: res=7.
- res_ready held low 5 cycles in DONE:
  - res and res_valid stable.
  - A start asserted during the hold is ignored.
  - IDLE is entered on the cycle res_ready rises.
- rst asserted mid-ACCUM after 2 of 6 beats:
  - Next cycle all outputs are 0 and the state is IDLE.
  - A new job with num_ops=1, psum=-9 gives res=-9.
  - With AC3_ACC_OVF_EN defined: a positive full-scale accumulation forced past 2^(ACC_W-1)-1 sets ovf, which stays set until the next CLEAR.
